regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port general-purpose register file for the CPU core, and the successor to the single-write, dual-read register file. It provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with register 0 hardwired to zero. A per-register busy scoreboard lets issue logic detect pending writebacks. Optional write-to-read bypass lets decode see same-cycle writebacks; it sits between decode/issue and the writeback stage.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, index width; NUM_REGS = 2**ADDR_W
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 2, write ports (1..2)
- clk  in  1  sole clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR×ADDR_W  write index per port
- wr_data  in  NUM_WR×DATA_W  write data per port
- rd_addr  in  NUM_RD×ADDR_W  read index per port
- rd_data  out  NUM_RD×DATA_W  read data per port
- rd_busy  out  NUM_RD  read register has a pending producer
- iss_en  in  1  issue of an instruction that writes a register
- iss_addr  in  ADDR_W  destination of that instruction
- any_busy  out  1  OR of all busy bits, used by drain/flush logic
- sb_clear  in  1  synchronous flush: clear all busy bits, registers untouched

## Operation
- Reset (rst=1, asynchronous): all registers go to 0 and all busy bits to 0. rd_data then shows 0 for every address, with rd_busy=0 and any_busy=0.
- Writes: on a rising edge with wr_en[i]=1 and wr_addr[i]≠0, the register takes wr_data[i]. Writes to index 0 are discarded.
- Write conflict: if both ports target the same nonzero index, port NUM_WR-1 wins.
- Reads: combinational. rd_data[j] = regs[rd_addr[j]], and index 0 always reads 0.
- Scoreboard set: iss_en with iss_addr≠0 sets busy[iss_addr] at the edge. iss_addr=0 is ignored.
- Scoreboard clear: each wr_en[i] with a nonzero address clears busy[wr_addr[i]] at the edge.
- Same-cycle set and clear on one index: the set wins, so busy stays 1 because a newer producer owns it.
- sb_clear has priority over iss_en and the writeback clears. All busy bits go to 0 at the edge, while the register writes in that cycle still complete.
- rd_busy[j] = busy[rd_addr[j]], adjusted for bypass as described under Configuration. Register 0 is never busy.
- Reset asserted mid-operation loses in-flight writes. Deassertion is synchronised externally, so no reset-release requirement applies here.

## Timing
- Write-to-read latency is 1 cycle without bypass and 0 cycles with bypass.
- Issue to rd_busy visible is 1 cycle. iss_en has no same-cycle effect on rd_busy.
- No handshake. All inputs are sampled every edge, and there are no stalls inside the block.
- The combinational read path is rd_addr → mux (→ bypass compare) → rd_data, with no state in between.

## Configuration
- REGFILE_BYPASS_EN defined:
  - if a read index matches an active nonzero write index this cycle, rd_data[j] = that wr_data, using the same priority as writes (highest port wins).
  - rd_busy[j] is forced to 0 on a bypass hit, unless iss_en targets the same index this cycle; in that case busy still reads the old bit, per the 1-cycle rule.
- REGFILE_BYPASS_EN undefined: reads return only stored state, and rd_busy reflects only the registered busy bits.

## Structure
- The shared CPU package holds:
  - the reg-index typedef (width ADDR_W, with REG_ZERO = 0)
  - the data word typedef and the zero-word constant
  - the port-count limits.
- Natural sub-module: regfile_scoreboard. It holds the busy vector with its set, clear and flush priority, and produces any_busy. The top level instantiates it alongside the storage array and read muxes.

## Test plan
- Reset, then read all 32 indices → rd_data=0 everywhere, rd_busy=0, any_busy=0. Assert rst mid-run after writing r5=0xDEADBEEF → r5 reads 0 immediately, without waiting for an edge.
- Write r0=0x12345678 on both ports, then read r0 → 0, and busy[0] is never set even with iss_en, iss_addr=0.
- Dual write to r7, with port0=0x11111111 and port1=0x22222222 → r7 reads 0x22222222 next cycle. Disjoint dual write r3=0xA, r4=0xB → both stored.
- Issue r9 → rd_busy=1 next cycle and any_busy=1. Write r9=0x55 → busy clears next cycle. Issue r9 and write r9 in the same cycle → busy remains 1.
- Busy set on r2 and r6, then sb_clear together with a write r6=0x77 → all busy bits 0 and any_busy=0 next cycle, and r6 reads 0x77.
- With REGFILE_BYPASS_EN, write r10=0xCAFE while reading r10 → rd_data=0xCAFE the same cycle and rd_busy=0. Without the macro → old value that cycle and 0xCAFE the next.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared CPU register-file package: register index and data word types, zero constants, port-count limits.
package regfile_mp_pkg;
   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;
   localparam int MAX_RD    = 4;
   localparam int MAX_WR    = 2;

   typedef logic [RF_ADDR_W-1:0] reg_idx_t;
   typedef logic [RF_DATA_W-1:0] word_t;

   localparam reg_idx_t REG_ZERO  = '0;
   localparam word_t    WORD_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, flush clears all; register 0 never busy.
module regfile_scoreboard
   import regfile_mp_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_WR = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           iss_en,
   input  logic [ADDR_W-1:0]              iss_addr,
   input  logic [NUM_WR-1:0]              wr_en,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
   input  logic                           sb_clear,
   output logic [(1<<ADDR_W)-1:0]         busy,
   output logic                           any_busy
);
   localparam int NUM_REGS = 1 << ADDR_W;

   logic [NUM_REGS-1:0] busy_q, busy_nxt;

   // Set is applied after the clears so a new producer keeps ownership.
   always_comb begin
      busy_nxt = busy_q;
      for (int i = 0; i < NUM_WR; i++)
         if (wr_en[i]) busy_nxt[wr_addr[i]] = 1'b0;
      if (iss_en) busy_nxt[iss_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           busy_q <= '0;
      else if (sb_clear) busy_q <= '0;
      else               busy_q <= busy_nxt;
   end

   assign busy     = busy_q;
   assign any_busy = |busy_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file (r0 hardwired zero) with busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writebacks onto the read ports.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_WR-1:0]              wr_en,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
   input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
   output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
   output logic [NUM_RD-1:0]              rd_busy,
   input  logic                           iss_en,
   input  logic [ADDR_W-1:0]              iss_addr,
   output logic                           any_busy,
   input  logic                           sb_clear
);
   localparam int NUM_REGS = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] IDX0  = ADDR_W'(REG_ZERO);
   localparam logic [DATA_W-1:0] ZWORD = DATA_W'(WORD_ZERO);

   if (NUM_RD < 1 || NUM_RD > MAX_RD) begin : g_bad_rd
      $error("regfile_mp: NUM_RD out of range");
   end
   if (NUM_WR < 1 || NUM_WR > MAX_WR) begin : g_bad_wr
      $error("regfile_mp: NUM_WR out of range");
   end

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;

   // Later ports are visited last, so the highest port wins a same-index conflict.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= ZWORD;
      end else begin
         for (int i = 0; i < NUM_WR; i++)
            if (wr_en[i] && wr_addr[i] != IDX0) regs[wr_addr[i]] <= wr_data[i];
      end
   end

   regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_sb (
      .clk      (clk),
      .rst      (rst),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .sb_clear (sb_clear),
      .busy     (busy),
      .any_busy (any_busy)
   );

   for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      logic [DATA_W-1:0] data;
      logic              bsy;

      always_comb begin
         data = regs[rd_addr[j]];
         bsy  = busy[rd_addr[j]];
`ifdef REGFILE_BYPASS_EN
         for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && wr_addr[i] != IDX0 && wr_addr[i] == rd_addr[j]) begin
               data = wr_data[i];
               if (!(iss_en && iss_addr == rd_addr[j])) bsy = 1'b0;
            end
         end
`endif
         if (rd_addr[j] == IDX0) begin
            data = ZWORD;
            bsy  = 1'b0;
         end
      end

      assign rd_data[j] = data;
      assign rd_busy[j] = bsy;
   end
endmodule

// File: tb/tb_regfile_mp.sv
// Randomized + directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
   localparam int DW = 32, AW = 5, NR = 2, NW = 2, NREG = 32;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NW-1:0]          wr_en;
   logic [NW-1:0][AW-1:0]  wr_addr;
   logic [NW-1:0][DW-1:0]  wr_data;
   logic [NR-1:0][AW-1:0]  rd_addr;
   logic [NR-1:0][DW-1:0]  rd_data;
   logic [NR-1:0]          rd_busy;
   logic                   iss_en;
   logic [AW-1:0]          iss_addr;
   logic                   any_busy;
   logic                   sb_clear;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .iss_en(iss_en),
      .iss_addr(iss_addr), .any_busy(any_busy), .sb_clear(sb_clear)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   logic [DW-1:0] m_regs [NREG];
   bit            m_busy [NREG];

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      for (int k = 0; k < NREG; k++) begin m_regs[k] = '0; m_busy[k] = 1'b0; end
   endtask

   function automatic logic [DW-1:0] exp_data(input int a);
      logic [DW-1:0] v;
      if (a == 0) return '0;
      v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < NW; i++) if (wr_en[i] && int'(wr_addr[i]) == a) v = wr_data[i];
`endif
      return v;
   endfunction

   function automatic bit exp_busy(input int a);
      bit b;
      if (a == 0) return 1'b0;
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < NW; i++)
         if (wr_en[i] && int'(wr_addr[i]) == a && !(iss_en && int'(iss_addr) == a)) b = 1'b0;
`endif
      return b;
   endfunction

   function automatic bit exp_any();
      bit b = 1'b0;
      for (int k = 0; k < NREG; k++) b |= m_busy[k];
      return b;
   endfunction

   // Apply this cycle's edge to the model: later port wins, writeback frees, issue claims, flush wipes.
   task automatic m_edge();
      bit nb [NREG];
      for (int k = 0; k < NREG; k++) nb[k] = m_busy[k];
      for (int i = 0; i < NW; i++)
         if (wr_en[i] && wr_addr[i] != 0) begin
            m_regs[wr_addr[i]] = wr_data[i];
            nb[wr_addr[i]] = 1'b0;
         end
      if (iss_en && iss_addr != 0) nb[iss_addr] = 1'b1;
      for (int k = 0; k < NREG; k++) m_busy[k] = sb_clear ? 1'b0 : nb[k];
   endtask

   task automatic check_reads();
      for (int j = 0; j < NR; j++) begin
         chk($sformatf("rd_data[%0d]@r%0d", j, rd_addr[j]), rd_data[j], exp_data(int'(rd_addr[j])));
         chk($sformatf("rd_busy[%0d]@r%0d", j, rd_addr[j]), DW'(rd_busy[j]), DW'(exp_busy(int'(rd_addr[j]))));
      end
      chk("any_busy", DW'(any_busy), DW'(exp_any()));
   endtask

   // Inputs change on negedge; outputs checked 1 time unit later, then the model follows the posedge.
   task automatic step();
      #1 check_reads();
      @(posedge clk);
      m_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      wr_en = '0; iss_en = 1'b0; sb_clear = 1'b0;
   endtask

   task automatic wr(input int p, input int a, input logic [DW-1:0] d);
      wr_en[p] = 1'b1; wr_addr[p] = AW'(a); wr_data[p] = d;
   endtask

   initial begin
      idle(); wr_addr = '0; wr_data = '0; rd_addr = '0; iss_addr = '0;
      rst = 1'b1; m_reset();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // all indices zero after reset
      for (int a = 0; a < NREG; a += NR) begin
         for (int j = 0; j < NR; j++) rd_addr[j] = AW'(a + j);
         #1 check_reads();
         chk("reset_any_busy", DW'(any_busy), 0);
         #1;
      end

      // write r5 then async reset mid-cycle
      wr(0, 5, 32'hDEADBEEF); step(); idle();
      rd_addr[0] = 5; #1 chk("r5_written", rd_data[0], 32'hDEADBEEF);
      rst = 1'b1; m_reset();
      #1 chk("r5_async_rst", rd_data[0], 0);
      @(negedge clk); rst = 1'b0;

      // r0 writes and issue to r0 are ignored
      wr(0, 0, 32'h12345678); wr(1, 0, 32'h12345678); iss_en = 1'b1; iss_addr = 0; step(); idle();
      rd_addr[0] = 0; #1 chk("r0_zero", rd_data[0], 0); chk("r0_not_busy", DW'(rd_busy[0]), 0);
      chk("r0_any_busy", DW'(any_busy), 0);

      // conflicting and disjoint dual writes
      wr(0, 7, 32'h11111111); wr(1, 7, 32'h22222222); step(); idle();
      rd_addr[0] = 7; #1 chk("dual_r7", rd_data[0], 32'h22222222);
      wr(0, 3, 32'hA); wr(1, 4, 32'hB); step(); idle();
      rd_addr[0] = 3; rd_addr[1] = 4;
      #1 chk("disj_r3", rd_data[0], 32'hA); chk("disj_r4", rd_data[1], 32'hB);

      // scoreboard set / clear / set-wins
      iss_en = 1'b1; iss_addr = 9; rd_addr[0] = 9;
      #1 chk("iss_no_same_cycle", DW'(rd_busy[0]), 0);
      step(); idle();
      #1 chk("busy_r9", DW'(rd_busy[0]), 1); chk("any_busy_r9", DW'(any_busy), 1);
      wr(0, 9, 32'h55); step(); idle();
      #1 chk("busy_r9_clr", DW'(rd_busy[0]), 0); chk("r9_data", rd_data[0], 32'h55);
      iss_en = 1'b1; iss_addr = 9; wr(1, 9, 32'h66); step(); idle();
      #1 chk("busy_r9_setwins", DW'(rd_busy[0]), 1);

      // flush with concurrent write
      iss_en = 1'b1; iss_addr = 2; step(); idle();
      iss_en = 1'b1; iss_addr = 6; step(); idle();
      sb_clear = 1'b1; wr(0, 6, 32'h77); step(); idle();
      rd_addr[0] = 6; rd_addr[1] = 2;
      #1 chk("flush_any", DW'(any_busy), 0); chk("flush_r6", rd_data[0], 32'h77);
      chk("flush_r2_busy", DW'(rd_busy[1]), 0);

      // write-to-read bypass (or its absence)
      wr(0, 10, 32'h1); step(); idle();
      iss_en = 1'b1; iss_addr = 10; step(); idle();
      wr(0, 10, 32'hCAFE); rd_addr[0] = 10;
`ifdef REGFILE_BYPASS_EN
      #1 chk("byp_data", rd_data[0], 32'hCAFE); chk("byp_busy", DW'(rd_busy[0]), 0);
`else
      #1 chk("nobyp_old", rd_data[0], 32'h1); chk("nobyp_busy", DW'(rd_busy[0]), 1);
`endif
      step(); idle();
      #1 chk("r10_next", rd_data[0], 32'hCAFE);

      // randomized traffic, addresses biased to a small window for collisions
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NW; i++) begin
            wr_en[i]   = ($urandom_range(0, 1) == 1);
            wr_addr[i] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NREG-1) : $urandom_range(0, 7));
            wr_data[i] = $urandom;
         end
         for (int j = 0; j < NR; j++)
            rd_addr[j] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NREG-1) : $urandom_range(0, 7));
         iss_en   = ($urandom_range(0, 9) < 3);
         iss_addr = AW'($urandom_range(0, 7));
         sb_clear = ($urandom_range(0, 19) == 0);
         step();
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
